plot_arbiter: RTL

Shares the single VGA adapter pixel-write port (x, y, colour, plot) among up to N sprite-drawing engines: border, ball(s), paddles, erase, game-over and game-start screens. Each engine requests the port for one whole sprite. The arbiter grants it round-robin and holds the grant until that engine's last pixel, so sprites are never interleaved. It replaces the priority mux and OR-ed writeEn in the game controller with a registered, handshaked write path. It also has a watchdog that reclaims the port from a stalled engine.

---
 rtl/plot_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Round-robin arbiter sharing the single VGA adapter pixel-write port among
//   N sprite-drawing engines. An engine keeps the port for a whole sprite
//   (until it presents a pixel with 'last'), so sprites never interleave.
//   A watchdog reclaims the port from an owner that stops requesting.
//
// Parameters
//   N        number of requesters (2..8)
//   IDX_W    owner index width, 2**IDX_W >= N
//   TIMEOUT  consecutive idle owner cycles before the grant is revoked (>= 2)
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   abort        synchronous clear: drop grant and pending plot, go IDLE
//   req[N]       per-requester pixel valid
//   last[N]      qualifies req: final pixel of the sprite
//   x_in[8N]     packed x, requester i at [8i+7:8i]
//   y_in[7N]     packed y, requester i at [7i+6:7i]
//   color_in[3N] packed colour, requester i at [3i+2:3i]
//   grant[N]     registered one-hot grant
//   plot         registered write strobe
//   x_out/y_out/color_out  registered pixel
//   owner        index of current or most recent grantee
//   busy         high while a sprite owns the port
//   timeout_evt  one-cycle pulse when the watchdog revokes a grant
module plot_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             abort,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     last,
  input  logic [8*N-1:0]   x_in,
  input  logic [7*N-1:0]   y_in,
  input  logic [3*N-1:0]   color_in,
  output logic [N-1:0]     grant,
  output logic             plot,
  output logic [7:0]       x_out,
  output logic [6:0]       y_out,
  output logic [2:0]       color_out,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             timeout_evt
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  logic [N-1:0]     grant_nxt;
  logic             plot_nxt;
  logic [7:0]       x_nxt;
  logic [6:0]       y_nxt;
  logic [2:0]       color_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic             timeout_nxt;

  // Owner's view of the request bus.
  logic             own_req, own_last, own_grant;
  logic [7:0]       own_x;
  logic [6:0]       own_y;
  logic [2:0]       own_color;

  // Round-robin winner.
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_oh;

  logic             accept;
  logic [IDX_W-1:0] owner_inc;

  assign busy = (state == BUSY);

  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    own_grant = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_color = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner == IDX_W'(i)) begin
        own_req   = req[i];
        own_last  = last[i];
        own_grant = grant[i];
        own_x     = x_in[8*i +: 8];
        own_y     = y_in[7*i +: 7];
        own_color = color_in[3*i +: 3];
      end
    end
  end

  // Search upward from ptr with wrap: first pass covers indices >= ptr,
  // second pass covers the wrapped-around lower indices. Indices >= N are
  // never visited, so unused owner codes cannot be selected.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found     = 1'b1;
        win_idx   = IDX_W'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        win_idx   = IDX_W'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  assign accept    = busy && own_req && own_grant;
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idle_cnt_nxt = idle_cnt;
    grant_nxt    = grant;
    plot_nxt     = 1'b0;
    x_nxt        = x_out;
    y_nxt        = y_out;
    color_nxt    = color_out;
    owner_nxt    = owner;
    timeout_nxt  = 1'b0;

    if (abort) begin
      state_nxt    = IDLE;
      grant_nxt    = '0;
      idle_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_nxt    = win_oh;
            owner_nxt    = win_idx;
            state_nxt    = BUSY;
            idle_cnt_nxt = '0;
          end
        end
        BUSY: begin
          if (accept) begin
            plot_nxt     = 1'b1;
            x_nxt        = own_x;
            y_nxt        = own_y;
            color_nxt    = own_color;
            idle_cnt_nxt = '0;
            if (own_last) begin
              grant_nxt = '0;
              state_nxt = IDLE;
              ptr_nxt   = owner_inc;
            end
          end else if (!own_req) begin
            // Fires on the TIMEOUT-th consecutive idle cycle.
            if (idle_cnt == CNT_MAX) begin
              grant_nxt    = '0;
              state_nxt    = IDLE;
              ptr_nxt      = owner_inc;
              idle_cnt_nxt = '0;
              timeout_nxt  = 1'b1;
            end else begin
              idle_cnt_nxt = idle_cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ptr         <= '0;
      idle_cnt    <= '0;
      grant       <= '0;
      plot        <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      color_out   <= '0;
      owner       <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      idle_cnt    <= idle_cnt_nxt;
      grant       <= grant_nxt;
      plot        <= plot_nxt;
      x_out       <= x_nxt;
      y_out       <= y_nxt;
      color_out   <= color_nxt;
      owner       <= owner_nxt;
      timeout_evt <= timeout_nxt;
    end
  end

endmodule
